// File: rtl/dec2_4_hold.sv
// Sequential 2-to-4 decoder with handshake input, timed one-hot hold and idle gap.
// Ports: clk, rst_n, en, in_valid, code[1:0] in; in_ready, y[3:0], busy, done out.
module dec2_4_hold #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    input  logic [1:0] code,
    output logic       in_ready,
    output logic [3:0] y,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Counter loads are one less than the phase length because the
    // terminal cycle is the one where cnt reads zero.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  =
        (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic [1:0] code_q;
    logic [1:0] code_q_nx;
    logic       done_nx;
    logic       cnt_zero;

    assign cnt_zero = (cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            code_q <= 2'd0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            code_q <= code_q_nx;
            done   <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        code_q_nx = code_q;
        done_nx   = 1'b0;
        if (!en) begin
            // Abort wins over any terminal count at the same edge.
            state_nx = IDLE;
            cnt_nx   = 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        code_q_nx = code;
                        cnt_nx    = HOLD_LOAD;
                        state_nx  = HOLD;
                    end
                end
                HOLD: begin
                    if (!cnt_zero) begin
                        cnt_nx = cnt - 8'd1;
                    end else begin
                        done_nx = 1'b1;
                        if (HAS_GAP) begin
                            state_nx = GAP;
                            cnt_nx   = GAP_LOAD;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (!cnt_zero) begin
                        cnt_nx = cnt - 8'd1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so they cannot glitch on inputs.
    always_comb begin
        y = 4'b0000;
        if (state == HOLD) begin
            y[code_q] = 1'b1;
        end
    end

    assign busy     = (state != IDLE);
    assign in_ready = en & (state == IDLE);

endmodule

// File: tb/tb_dec2_4_hold.sv
// Testbench for dec2_4_hold: two instances (4/1 and 1/0 hold/gap)
// checked against a cycle-age reference model plus directed expectations.
module tb_dec2_4_hold;

    localparam int HA  = 4;
    localparam int GA  = 1;
    localparam int HB  = 1;
    localparam int GB  = 0;
    localparam int BIG = 1000;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [1:0] code;

    logic       a_rdy;
    logic [3:0] a_y;
    logic       a_busy;
    logic       a_done;
    logic       b_rdy;
    logic [3:0] b_y;
    logic       b_busy;
    logic       b_done;

    int checks;
    int errors;
    int cyc;

    dec2_4_hold #(.HOLD_CYCLES(HA), .GAP_CYCLES(GA)) u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_valid (in_valid),
        .code     (code),
        .in_ready (a_rdy),
        .y        (a_y),
        .busy     (a_busy),
        .done     (a_done)
    );

    dec2_4_hold #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB)) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_valid (in_valid),
        .code     (code),
        .in_ready (b_rdy),
        .y        (b_y),
        .busy     (b_busy),
        .done     (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: age = edges since the last accept (BIG when none
    // or aborted). y is on for ages 0..H-1, busy for ages below H+G,
    // done exactly at age H.
    int         sa, sb;
    logic [1:0] ca, cb;
    logic       da, db;

    task automatic mstep(inout int s, inout logic [1:0] c,
                         inout logic d, input int h, input int g);
        if (!en) begin
            s = BIG;
            d = 1'b0;
        end else if (in_valid && s >= h + g) begin
            s = 0;
            c = code;
            d = 1'b0;
        end else begin
            if (s < BIG) s = s + 1;
            d = (s == h);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa = BIG; sb = BIG;
            ca = 2'd0; cb = 2'd0;
            da = 1'b0; db = 1'b0;
        end else begin
            mstep(sa, ca, da, HA, GA);
            mstep(sb, cb, db, HB, GB);
        end
    end

    function automatic logic [6:0] exp_vec(input int s, input logic [1:0] c,
                                           input logic d, input int h,
                                           input int g);
        logic [3:0] one;
        logic [3:0] yy;
        logic       bz;
        one = 4'b0001;
        yy  = (s < h) ? (one << c) : 4'b0000;
        bz  = (s < h + g);
        return {yy, bz, d, en & ~bz};
    endfunction

    task automatic drain();
        en = 1'b1;
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; code = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_y, a_busy, a_done, a_rdy} !== 7'd0) begin
            errors++;
            $display("FAIL reset_a got %b want 0000000",
                     {a_y, a_busy, a_done, a_rdy});
        end
        checks++;
        if ({b_y, b_busy, b_done, b_rdy} !== 7'd0) begin
            errors++;
            $display("FAIL reset_b got %b want 0000000",
                     {b_y, b_busy, b_done, b_rdy});
        end
        rst_n = 1'b1;
        en = 1'b1;
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready got %b want 11", {a_rdy, b_rdy});
        end
    endtask

    task automatic test_async_reset();
        drain();
        code = 2'd2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (a_y !== 4'b0100 || b_y !== 4'b0100) begin
            errors++;
            $display("FAIL arst_pre got a=%b b=%b want 0100", a_y, b_y);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_y, a_busy, a_done, b_y, b_busy, b_done} !== 12'd0) begin
            errors++;
            $display("FAIL arst_now got a=%b/%b/%b b=%b/%b/%b want zeros",
                     a_y, a_busy, a_done, b_y, b_busy, b_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_rdy !== 1'b1) begin
            errors++;
            $display("FAIL arst_ready got %b want 1", a_rdy);
        end
    endtask

    task automatic test_basic();
        int ycnt, dcnt, didx, ridx;
        drain();
        code = 2'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ycnt = 0; dcnt = 0; didx = -1; ridx = -1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({a_y, a_busy, a_done, a_rdy} !==
                exp_vec(sa, ca, da, HA, GA)) begin
                errors++;
                $display("FAIL basic_model k=%0d got %b want %b", k,
                         {a_y, a_busy, a_done, a_rdy},
                         exp_vec(sa, ca, da, HA, GA));
            end
            if (a_y == 4'b1000) ycnt++;
            if (a_done) begin
                dcnt++;
                didx = k;
            end
            if (a_rdy && ridx < 0) ridx = k;
            @(negedge clk);
        end
        checks++;
        if (ycnt != 4 || dcnt != 1 || didx != 4 || ridx != 5) begin
            errors++;
            $display("FAIL basic_timing got y=%0d d=%0d@%0d rdy@%0d want 4 1@4 5",
                     ycnt, dcnt, didx, ridx);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] one;
        int prev, found, hold;
        one = 4'b0001;
        drain();
        code = 2'd0; in_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            found = 0;
            for (int w = 0; w < 20 && !found; w++) begin
                @(negedge clk);
                if (a_y != 4'b0000) found = 1;
            end
            checks++;
            if (!found || a_y !== (one << i)) begin
                errors++;
                $display("FAIL b2b_code%0d got %b want %b", i, a_y, one << i);
            end
            if (i > 0) begin
                checks++;
                if (cyc - prev != 6) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d got %0d want 6", i, cyc - prev);
                end
            end
            prev = cyc;
            code = 2'(i + 1);
            hold = 1;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (a_y == (one << i)) hold++;
                else break;
            end
            checks++;
            if (hold != HA) begin
                errors++;
                $display("FAIL b2b_hold%0d got %0d want %0d", i, hold, HA);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_min();
        logic [3:0] want;
        drain();
        code = 2'b01; in_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            want = (k % 2) ? 4'b0000 : (((k / 2) % 2) ? 4'b0100 : 4'b0010);
            checks++;
            if (b_y !== want) begin
                errors++;
                $display("FAIL min_y k=%0d got %b want %b", k, b_y, want);
            end
            checks++;
            if ({b_y, b_busy, b_done, b_rdy} !==
                exp_vec(sb, cb, db, HB, GB)) begin
                errors++;
                $display("FAIL min_model k=%0d got %b want %b", k,
                         {b_y, b_busy, b_done, b_rdy},
                         exp_vec(sb, cb, db, HB, GB));
            end
            if (k % 2) begin
                checks++;
                if ({b_done, b_rdy} !== 2'b11) begin
                    errors++;
                    $display("FAIL min_done_ready k=%0d got %b want 11",
                             k, {b_done, b_rdy});
                end
            end
            if (b_y != 4'b0000) code = ~code;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_abort();
        int dcnt;
        drain();
        code = 2'b01; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_y !== 4'b0010) begin
            errors++;
            $display("FAIL abort_hold2 got %b want 0010", a_y);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_y, a_busy, a_done, a_rdy} !== 7'd0) begin
            errors++;
            $display("FAIL abort_clear got %b want 0000000",
                     {a_y, a_busy, a_done, a_rdy});
        end
        en = 1'b1;
        #1;
        checks++;
        if (a_rdy !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got %b want 1", a_rdy);
        end
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_done) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL abort_nodone got %0d pulses want 0", dcnt);
        end
    endtask

    task automatic test_backpressure();
        int hold, found;
        drain();
        code = 2'b00; in_valid = 1'b1;
        @(negedge clk);
        code = 2'b11;
        hold = 0;
        for (int w = 0; w < 10; w++) begin
            if (a_y == 4'b0001) hold++;
            else break;
            @(negedge clk);
        end
        checks++;
        if (hold != HA) begin
            errors++;
            $display("FAIL bp_hold got %0d want %0d", hold, HA);
        end
        found = -1;
        for (int w = 0; w < 10 && found < 0; w++) begin
            if (a_y == 4'b1000) found = w;
            else @(negedge clk);
        end
        checks++;
        if (found != 2) begin
            errors++;
            $display("FAIL bp_newcode got wait=%0d y=%b want 2 1000", found, a_y);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        drain();
        for (int k = 0; k < 400; k++) begin
            checks++;
            if ({a_y, a_busy, a_done, a_rdy} !==
                exp_vec(sa, ca, da, HA, GA)) begin
                errors++;
                $display("FAIL rand_a k=%0d got %b want %b", k,
                         {a_y, a_busy, a_done, a_rdy},
                         exp_vec(sa, ca, da, HA, GA));
            end
            checks++;
            if ({b_y, b_busy, b_done, b_rdy} !==
                exp_vec(sb, cb, db, HB, GB)) begin
                errors++;
                $display("FAIL rand_b k=%0d got %b want %b", k,
                         {b_y, b_busy, b_done, b_rdy},
                         exp_vec(sb, cb, db, HB, GB));
            end
            en       = ($urandom_range(0, 15) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            code     = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        in_valid = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_min();
        test_abort();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
